// File: rtl/layer_share_pkg.sv
// Shared types and sizing helpers for the layer sharing arbiter.
package layer_share_pkg;

    // Input-side lock state: FREE lets round-robin choose, LOCKED pins the grant
    // until the layer accepts the beat already presented.
    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_t;

    // Width of a requester ID tag; never less than one bit.
    function automatic int calc_tag_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_TAG_W = calc_tag_w(4);

endpackage

// File: rtl/layer_share_tag_fifo.sv
// Tag FIFO holding the requester ID of each input the layer has accepted,
// in acceptance order, so results can be routed back to their owners.
module layer_share_tag_fifo
    import layer_share_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int CNT_W = calc_cnt_w(DEPTH),
    localparam int PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Tag storage write port.
    // NOTE: storage has no reset; only entries counted by r_count are ever consumed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop in one cycle cancel in the count.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/layer_share_arbiter.sv
// Time-multiplexes one in-order valid/ready layer wrapper across NUM_REQ streams:
// round-robin on the input side, tag FIFO routing of results on the output side.
module layer_share_arbiter
    import layer_share_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int IN_W            = 16,
    parameter int OUT_W           = 66,
    parameter int MAX_OUTSTANDING = 4,
    localparam int TAG_W = calc_tag_w(NUM_REQ),
    localparam int CNT_W = calc_cnt_w(MAX_OUTSTANDING)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][IN_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [OUT_W-1:0]               resp_data,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic                           layer_in_valid,
    output logic [IN_W-1:0]                layer_in_data,
    input  logic                           layer_in_ready,
    input  logic                           layer_out_valid,
    input  logic [OUT_W-1:0]               layer_out_data,
    output logic                           layer_out_ready,
    output logic [CNT_W-1:0]               outstanding,
    output logic                           err_orphan
);

    arb_state_t       r_state;
    logic [TAG_W-1:0] r_lock_id;
    logic [TAG_W-1:0] r_rr_ptr;
    logic             r_err_orphan;

    logic [TAG_W-1:0] w_cand;
    logic [TAG_W-1:0] w_grant;
    logic [TAG_W-1:0] w_head;
    logic             w_run;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;

    // Outputs are forced idle while reset is asserted, not just after it.
    assign w_run = ~rst;

    // Round-robin search starting just after the last granted requester.
    // Walking the offsets from far to near lets the nearest valid requester win.
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        logic [TAG_W-1:0] idx;
        w_cand = '0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = TAG_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                w_cand = idx;
            end
        end
    end

    assign w_grant        = (r_state == ARB_LOCKED) ? r_lock_id : w_cand;
    assign layer_in_valid = w_run & ~w_full & ((r_state == ARB_LOCKED) | (|req_valid));
    assign layer_in_data  = req_data[w_grant];
    assign w_push         = layer_in_valid & layer_in_ready;

    // Only the granted requester sees ready, and only on an actual layer handshake.
    always_comb begin
        req_ready          = '0;
        req_ready[w_grant] = w_push;
    end

    // Result routing: the FIFO head names the owner of the next in-order layer output.
    always_comb begin
        resp_valid = '0;
        if (w_run && !w_empty) begin
            resp_valid[w_head] = layer_out_valid;
        end
    end

    // An empty FIFO drains the layer so stray results cannot block it.
    assign layer_out_ready = w_run & (w_empty | resp_ready[w_head]);
    assign resp_data       = layer_out_data;
    assign w_pop           = ~w_empty & layer_out_valid & layer_out_ready;
    assign outstanding     = w_count;
    assign err_orphan      = r_err_orphan;

    layer_share_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_grant),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Lock FSM and round-robin pointer: pin a presented-but-stalled grant, advance on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_FREE;
            r_lock_id <= '0;
            r_rr_ptr  <= TAG_W'(NUM_REQ - 1);
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_grant;
            end
            case (r_state)
                ARB_FREE: begin
                    if (layer_in_valid && !layer_in_ready) begin
                        r_state   <= ARB_LOCKED;
                        r_lock_id <= w_grant;
                    end
                end
                ARB_LOCKED: begin
                    if (w_push) begin
                        r_state <= ARB_FREE;
                    end
                end
                default: r_state <= ARB_FREE;
            endcase
        end
    end

    // Sticky flag for a layer result that arrives when no tag is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_orphan <= 1'b0;
        end else if (w_empty && layer_out_valid) begin
            r_err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_layer_share_arbiter.sv
// Directed bench for layer_share_arbiter: a cycle-by-cycle vector table followed by
// hand-written sequences for single-stream streaming and asynchronous reset mid-burst.
module tb_layer_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IN_W    = 16;
    localparam int OUT_W   = 66;
    localparam int MAXO    = 2;
    localparam int NVEC    = 19;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][IN_W-1:0]  req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [OUT_W-1:0]              resp_data;
    logic [NUM_REQ-1:0]            resp_ready;
    logic                          layer_in_valid;
    logic [IN_W-1:0]               layer_in_data;
    logic                          layer_in_ready;
    logic                          layer_out_valid;
    logic [OUT_W-1:0]              layer_out_data;
    logic                          layer_out_ready;
    logic [1:0]                    outstanding;
    logic                          err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  rv;
        logic        lir;
        logic        lov;
        logic [3:0]  rr;
        logic [3:0]  e_rq;
        logic        e_liv;
        logic [15:0] e_lid;
        logic [3:0]  e_rsv;
        logic        e_lor;
        logic [1:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs [NVEC];

    layer_share_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .IN_W            (IN_W),
        .OUT_W           (OUT_W),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_ready      (resp_ready),
        .layer_in_valid  (layer_in_valid),
        .layer_in_data   (layer_in_data),
        .layer_in_ready  (layer_in_ready),
        .layer_out_valid (layer_out_valid),
        .layer_out_data  (layer_out_data),
        .layer_out_ready (layer_out_ready),
        .outstanding     (outstanding),
        .err_orphan      (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic lir, input logic lov,
                                input logic [3:0] rr, input logic [3:0] e_rq, input logic e_liv,
                                input logic [15:0] e_lid, input logic [3:0] e_rsv,
                                input logic e_lor, input logic [1:0] e_out, input logic e_err);
        vec_t v;
        v.rv = rv; v.lir = lir; v.lov = lov; v.rr = rr;
        v.e_rq = e_rq; v.e_liv = e_liv; v.e_lid = e_lid; v.e_rsv = e_rsv;
        v.e_lor = e_lor; v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        // Round-robin over all four, full FIFO stall, held response, push+pop, lock, orphan.
        vecs[0]  = mk(4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0000, 1, 0, 0);
        vecs[1]  = mk(4'b1111, 1, 0, 4'b1111, 4'b0001, 1, 16'hA000, 4'b0000, 1, 0, 0);
        vecs[2]  = mk(4'b1111, 1, 0, 4'b1111, 4'b0010, 1, 16'hA001, 4'b0000, 1, 1, 0);
        vecs[3]  = mk(4'b1111, 1, 1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0001, 1, 2, 0);
        vecs[4]  = mk(4'b1111, 1, 1, 4'b1111, 4'b0100, 1, 16'hA002, 4'b0010, 1, 1, 0);
        vecs[5]  = mk(4'b1111, 1, 0, 4'b1111, 4'b1000, 1, 16'hA003, 4'b0000, 1, 1, 0);
        vecs[6]  = mk(4'b1000, 1, 1, 4'b1011, 4'b0000, 0, 16'h0000, 4'b0100, 0, 2, 0);
        vecs[7]  = mk(4'b1000, 1, 1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0100, 1, 2, 0);
        vecs[8]  = mk(4'b1000, 1, 1, 4'b1111, 4'b1000, 1, 16'hA003, 4'b1000, 1, 1, 0);
        vecs[9]  = mk(4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b1000, 1, 1, 0);
        vecs[10] = mk(4'b0010, 0, 0, 4'b1111, 4'b0000, 1, 16'hA001, 4'b0000, 1, 0, 0);
        vecs[11] = mk(4'b0011, 0, 0, 4'b1111, 4'b0000, 1, 16'hA001, 4'b0000, 1, 0, 0);
        vecs[12] = mk(4'b0011, 1, 0, 4'b1111, 4'b0010, 1, 16'hA001, 4'b0000, 1, 0, 0);
        vecs[13] = mk(4'b0001, 1, 0, 4'b1111, 4'b0001, 1, 16'hA000, 4'b0000, 1, 1, 0);
        vecs[14] = mk(4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0010, 1, 2, 0);
        vecs[15] = mk(4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0001, 1, 1, 0);
        vecs[16] = mk(4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0000, 1, 0, 0);
        vecs[17] = mk(4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0000, 1, 0, 1);
        vecs[18] = mk(4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0000, 1, 0, 1);

        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = 16'hA000 + 16'(i);
        end

        // Reset held with every input active: all handshake outputs must stay low.
        rst             = 1'b1;
        req_valid       = 4'b1111;
        resp_ready      = 4'b1111;
        layer_in_ready  = 1'b1;
        layer_out_valid = 1'b1;
        layer_out_data  = '0;
        #3;
        check("rst req_ready", OUT_W'(req_ready), OUT_W'(4'b0000));
        check("rst layer_in_valid", OUT_W'(layer_in_valid), OUT_W'(1'b0));
        check("rst resp_valid", OUT_W'(resp_valid), OUT_W'(4'b0000));
        check("rst layer_out_ready", OUT_W'(layer_out_ready), OUT_W'(1'b0));
        check("rst outstanding", OUT_W'(outstanding), OUT_W'(2'd0));
        check("rst err_orphan", OUT_W'(err_orphan), OUT_W'(1'b0));
        @(negedge clk);
        check("rst err_orphan held", OUT_W'(err_orphan), OUT_W'(1'b0));
        rst = 1'b0;

        // Table: inputs applied after a falling edge, outputs sampled before the rising edge.
        for (int r = 0; r < NVEC; r++) begin
            req_valid       = vecs[r].rv;
            layer_in_ready  = vecs[r].lir;
            layer_out_valid = vecs[r].lov;
            resp_ready      = vecs[r].rr;
            layer_out_data  = 66'h2_5555_0000_0000_0000 + OUT_W'(r);
            #2;
            check($sformatf("row%0d req_ready", r), OUT_W'(req_ready), OUT_W'(vecs[r].e_rq));
            check($sformatf("row%0d layer_in_valid", r), OUT_W'(layer_in_valid), OUT_W'(vecs[r].e_liv));
            if (vecs[r].e_liv) begin
                check($sformatf("row%0d layer_in_data", r), OUT_W'(layer_in_data), OUT_W'(vecs[r].e_lid));
            end
            check($sformatf("row%0d resp_valid", r), OUT_W'(resp_valid), OUT_W'(vecs[r].e_rsv));
            if (vecs[r].e_rsv != 4'b0000) begin
                check($sformatf("row%0d resp_data", r), resp_data, 66'h2_5555_0000_0000_0000 + OUT_W'(r));
            end
            check($sformatf("row%0d layer_out_ready", r), OUT_W'(layer_out_ready), OUT_W'(vecs[r].e_lor));
            check($sformatf("row%0d outstanding", r), OUT_W'(outstanding), OUT_W'(vecs[r].e_out));
            check($sformatf("row%0d err_orphan", r), OUT_W'(err_orphan), OUT_W'(vecs[r].e_err));
            @(negedge clk);
        end

        // Single stream: requester 2 alone, five items, results returned in order.
        resp_ready     = 4'b1111;
        layer_in_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid       = 4'b0100;
            layer_out_valid = 1'b0;
            #2;
            check($sformatf("solo%0d req_ready", k), OUT_W'(req_ready), OUT_W'(4'b0100));
            check($sformatf("solo%0d layer_in_data", k), OUT_W'(layer_in_data), OUT_W'(16'hA002));
            @(negedge clk);
            req_valid       = 4'b0000;
            layer_out_valid = 1'b1;
            layer_out_data  = 66'h1_0000_0000_CAFE_0000 + OUT_W'(k);
            #2;
            check($sformatf("solo%0d resp_valid", k), OUT_W'(resp_valid), OUT_W'(4'b0100));
            check($sformatf("solo%0d resp_data", k), resp_data, 66'h1_0000_0000_CAFE_0000 + OUT_W'(k));
            check($sformatf("solo%0d outstanding", k), OUT_W'(outstanding), OUT_W'(2'd1));
            @(negedge clk);
        end

        // Burst from all requesters, then asynchronous reset with tags in flight.
        layer_out_valid = 1'b0;
        req_valid       = 4'b1111;
        #2;
        check("burst grant3", OUT_W'(req_ready), OUT_W'(4'b1000));
        @(negedge clk);
        #2;
        check("burst grant0", OUT_W'(req_ready), OUT_W'(4'b0001));
        @(negedge clk);
        layer_out_valid = 1'b1;
        #1;
        check("burst outstanding", OUT_W'(outstanding), OUT_W'(2'd2));
        rst = 1'b1;
        #1;
        check("midrst outstanding", OUT_W'(outstanding), OUT_W'(2'd0));
        check("midrst err_orphan", OUT_W'(err_orphan), OUT_W'(1'b0));
        check("midrst layer_in_valid", OUT_W'(layer_in_valid), OUT_W'(1'b0));
        check("midrst req_ready", OUT_W'(req_ready), OUT_W'(4'b0000));
        check("midrst resp_valid", OUT_W'(resp_valid), OUT_W'(4'b0000));
        check("midrst layer_out_ready", OUT_W'(layer_out_ready), OUT_W'(1'b0));
        @(negedge clk);
        check("midrst err held", OUT_W'(err_orphan), OUT_W'(1'b0));
        rst       = 1'b0;
        req_valid = 4'b0000;
        #2;
        check("orphan drain ready", OUT_W'(layer_out_ready), OUT_W'(1'b1));
        check("orphan resp_valid", OUT_W'(resp_valid), OUT_W'(4'b0000));
        @(negedge clk);
        layer_out_valid = 1'b0;
        #2;
        check("orphan err set", OUT_W'(err_orphan), OUT_W'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
